// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing producer (hsync, vsync, hpos, vpos, visible,
// line/frame strobes, frame counter). Every output is driven from a flop.
// Optional build macro VGA_TIMING_CE_EN adds a pix_ce advance-enable input.
module vga_timing_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0
) (
  input  logic       clk,
  input  logic       rst,
`ifdef VGA_TIMING_CE_EN
  input  logic       pix_ce,
`endif
  output logic       hsync,
  output logic       vsync,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       visible,
  output logic       line_start,
  output logic       frame_start,
  output logic [9:0] frame_count
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  // Last position of each phase; a phase is left on the edge after its last position.
  localparam logic [9:0] H_ACT_LAST   = 10'(H_DISPLAY - 1);
  localparam logic [9:0] H_FRONT_LAST = 10'(H_DISPLAY + H_FRONT - 1);
  localparam logic [9:0] H_SYNC_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_ACT_LAST   = 10'(V_DISPLAY - 1);
  localparam logic [9:0] V_FRONT_LAST = 10'(V_DISPLAY + V_FRONT - 1);
  localparam logic [9:0] V_SYNC_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);

  localparam logic HS_ON = (HSYNC_POL != 0);
  localparam logic VS_ON = (VSYNC_POL != 0);

  localparam bit PARAMS_OK = (H_DISPLAY >= 1) && (H_FRONT >= 1) && (H_SYNC >= 1) &&
                             (H_BACK >= 1) && (V_DISPLAY >= 1) && (V_FRONT >= 1) &&
                             (V_SYNC >= 1) && (V_BACK >= 1) &&
                             (H_TOTAL <= 1024) && (V_TOTAL <= 1024);

  typedef enum logic [1:0] {
    PH_ACTIVE,
    PH_FRONT,
    PH_SYNC,
    PH_BACK
  } phase_t;

  logic [9:0] r_hpos;
  logic [9:0] r_vpos;
  logic [9:0] r_frame_count;
  phase_t     r_h_state;
  phase_t     r_v_state;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_visible;
  logic       r_line_start;
  logic       r_frame_start;

  logic       w_adv;
  logic       w_h_wrap;
  logic       w_v_wrap;
  logic [9:0] w_hpos_nxt;
  logic [9:0] w_vpos_nxt;
  phase_t     w_h_state_nxt;
  phase_t     w_v_state_nxt;

`ifdef VGA_TIMING_CE_EN
  assign w_adv = pix_ce;
`else
  assign w_adv = 1'b1;
`endif

  // Next counter values and phase transitions for an advancing edge.
  always_comb begin
    w_h_wrap      = (r_hpos == H_LAST);
    w_v_wrap      = (r_vpos == V_LAST);
    w_hpos_nxt    = w_h_wrap ? '0 : r_hpos + 10'd1;
    w_vpos_nxt    = r_vpos;
    w_h_state_nxt = r_h_state;
    w_v_state_nxt = r_v_state;
    if (w_h_wrap) begin
      w_vpos_nxt = w_v_wrap ? '0 : r_vpos + 10'd1;
    end
    unique case (r_h_state)
      PH_ACTIVE: if (r_hpos == H_ACT_LAST)   w_h_state_nxt = PH_FRONT;
      PH_FRONT:  if (r_hpos == H_FRONT_LAST) w_h_state_nxt = PH_SYNC;
      PH_SYNC:   if (r_hpos == H_SYNC_LAST)  w_h_state_nxt = PH_BACK;
      PH_BACK:   if (w_h_wrap)               w_h_state_nxt = PH_ACTIVE;
      default:                               w_h_state_nxt = PH_BACK;
    endcase
    if (w_h_wrap) begin
      unique case (r_v_state)
        PH_ACTIVE: if (r_vpos == V_ACT_LAST)   w_v_state_nxt = PH_FRONT;
        PH_FRONT:  if (r_vpos == V_FRONT_LAST) w_v_state_nxt = PH_SYNC;
        PH_SYNC:   if (r_vpos == V_SYNC_LAST)  w_v_state_nxt = PH_BACK;
        PH_BACK:   if (w_v_wrap)               w_v_state_nxt = PH_ACTIVE;
        default:                               w_v_state_nxt = PH_BACK;
      endcase
    end
  end

  // Counters, phase FSMs and all outputs; outputs are computed from next state
  // so they land in the same cycle as the position they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hpos        <= H_LAST;
      r_vpos        <= V_LAST;
      r_h_state     <= PH_BACK;
      r_v_state     <= PH_BACK;
      r_frame_count <= '1;
      r_hsync       <= ~HS_ON;
      r_vsync       <= ~VS_ON;
      r_visible     <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (w_adv) begin
      r_hpos        <= w_hpos_nxt;
      r_vpos        <= w_vpos_nxt;
      r_h_state     <= w_h_state_nxt;
      r_v_state     <= w_v_state_nxt;
      if (w_h_wrap && w_v_wrap) begin
        r_frame_count <= r_frame_count + 10'd1;
      end
      r_hsync       <= (w_h_state_nxt == PH_SYNC) ? HS_ON : ~HS_ON;
      r_vsync       <= (w_v_state_nxt == PH_SYNC) ? VS_ON : ~VS_ON;
      r_visible     <= (w_h_state_nxt == PH_ACTIVE) && (w_v_state_nxt == PH_ACTIVE);
      r_line_start  <= w_h_wrap;
      r_frame_start <= w_h_wrap && w_v_wrap;
    end else begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end
  end

  // Parameter legality guard, evaluated in simulation.
  always_ff @(posedge clk) begin
    assert (PARAMS_OK) else $error("vga_timing_gen: illegal timing parameters");
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign hpos        = r_hpos;
  assign vpos        = r_vpos;
  assign visible     = r_visible;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scaled-down raster (8 x 6) checked cycle by cycle against
// a positional reference model. Build with VGA_TIMING_CE_EN to cover pix_ce.
module tb_vga_timing_gen;

  localparam int HD = 4, HF = 1, HS = 2, HB = 1;
  localparam int VD = 2, VF = 1, VS = 2, VB = 1;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam logic HS_ON = 1'b0;
  localparam logic VS_ON = 1'b1;
`ifdef VGA_TIMING_CE_EN
  localparam bit CE_PRESENT = 1'b1;
`else
  localparam bit CE_PRESENT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pix_ce = 1'b1;
  logic       hsync, vsync, visible, line_start, frame_start;
  logic [9:0] hpos, vpos, frame_count;
  logic [34:0] actual;

  int total = 0;
  int bad = 0;

  // Reference model state: position, frame number, whether the last edge advanced.
  int m_h = 0, m_v = 0, m_fc = 0;
  bit m_adv = 1'b0;

  vga_timing_gen #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_POL(0), .VSYNC_POL(1)
  ) dut (
    .clk(clk),
    .rst(rst),
`ifdef VGA_TIMING_CE_EN
    .pix_ce(pix_ce),
`endif
    .hsync(hsync),
    .vsync(vsync),
    .hpos(hpos),
    .vpos(vpos),
    .visible(visible),
    .line_start(line_start),
    .frame_start(frame_start),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  assign actual = {hsync, vsync, visible, line_start, frame_start, hpos, vpos, frame_count};

  // Outputs implied by the model position, derived from the raster geometry.
  function automatic logic [34:0] expected();
    logic hs, vs, vis, ls, fs;
    hs  = (m_h >= HD + HF && m_h < HD + HF + HS) ? HS_ON : ~HS_ON;
    vs  = (m_v >= VD + VF && m_v < VD + VF + VS) ? VS_ON : ~VS_ON;
    vis = (m_h < HD) && (m_v < VD);
    ls  = m_adv && (m_h == 0);
    fs  = ls && (m_v == 0);
    return {hs, vs, vis, ls, fs, 10'(m_h), 10'(m_v), 10'(m_fc)};
  endfunction

  // One clock: apply inputs, advance the model on the edge, settle outputs.
  task automatic tick(input bit rst_v, input bit ce_v);
    rst    = rst_v;
    pix_ce = CE_PRESENT ? ce_v : 1'b1;
    @(posedge clk);
    if (rst_v) begin
      m_h = HT - 1; m_v = VT - 1; m_fc = 1023; m_adv = 1'b0;
    end else if (pix_ce) begin
      m_adv = 1'b1;
      m_h = m_h + 1;
      if (m_h == HT) begin
        m_h = 0;
        m_v = m_v + 1;
        if (m_v == VT) begin
          m_v = 0;
          m_fc = (m_fc + 1) % 1024;
        end
      end
    end else begin
      m_adv = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1);
      total++;
      if ({hpos, vpos, frame_count, hsync, vsync, visible, line_start, frame_start} !==
          {10'(HT - 1), 10'(VT - 1), 10'h3FF, 1'b1, 1'b0, 3'b000}) begin
        bad++;
        $display("FAIL reset_state: got %h want %h", actual, expected());
      end
    end
    tick(1'b0, 1'b1);
    total++;
    if ({hpos, vpos, visible, line_start, frame_start, frame_count, hsync, vsync} !==
        {10'd0, 10'd0, 3'b111, 10'd0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL first_edge: got %h want %h", actual, expected());
    end
  endtask

  task automatic test_line();
    int hs_cnt = 0, ls_cnt = 0, vis_cnt = 0;
    for (int i = 0; i < HT; i++) begin
      tick(1'b0, 1'b1);
      total++;
      if (actual !== expected()) begin
        bad++;
        $display("FAIL line_model: got %h want %h", actual, expected());
      end
      if (hsync == HS_ON) hs_cnt++;
      if (line_start) ls_cnt++;
      if (visible) vis_cnt++;
    end
    total++;
    if (hs_cnt != HS) begin
      bad++;
      $display("FAIL hsync_width: got %0d want %0d", hs_cnt, HS);
    end
    total++;
    if (ls_cnt != 1) begin
      bad++;
      $display("FAIL line_start_count: got %0d want 1", ls_cnt);
    end
    total++;
    if (vis_cnt != HD) begin
      bad++;
      $display("FAIL visible_count: got %0d want %0d", vis_cnt, HD);
    end
  endtask

  task automatic test_frame();
    int vs_cnt = 0, fs_cnt = 0;
    for (int i = 0; i < FT; i++) begin
      tick(1'b0, 1'b1);
      total++;
      if (actual !== expected()) begin
        bad++;
        $display("FAIL frame_model: got %h want %h", actual, expected());
      end
      if (vsync == VS_ON) vs_cnt++;
      if (frame_start) fs_cnt++;
    end
    total++;
    if (vs_cnt != VS * HT) begin
      bad++;
      $display("FAIL vsync_width: got %0d want %0d", vs_cnt, VS * HT);
    end
    total++;
    if (fs_cnt != 1) begin
      bad++;
      $display("FAIL frame_start_count: got %0d want 1", fs_cnt);
    end
    total++;
    if (frame_count !== 10'd1) begin
      bad++;
      $display("FAIL frame_count_one: got %0d want 1", frame_count);
    end
  endtask

  task automatic test_frame_wrap();
    bit seen = 1'b0;
    logic [9:0] prev;
    prev = frame_count;
    for (int i = 0; i < 1024 * FT; i++) begin
      tick(1'b0, 1'b1);
      total++;
      if (actual !== expected()) begin
        bad++;
        $display("FAIL wrap_model: got %h want %h", actual, expected());
      end
      if (prev == 10'h3FF && frame_count == 10'd0) seen = 1'b1;
      prev = frame_count;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL frame_count_wrap: got no 1023->0 step want one");
    end
    total++;
    if (frame_count !== 10'd1) begin
      bad++;
      $display("FAIL frame_count_after_wrap: got %0d want 1", frame_count);
    end
  endtask

  task automatic test_mid_reset();
    int budget = 0;
    while (!(m_h == 6 && m_v == 3) && budget < FT + 1) begin
      tick(1'b0, 1'b1);
      budget++;
    end
    total++;
    if (!(m_h == 6 && m_v == 3)) begin
      bad++;
      $display("FAIL mid_reset_reach: got (%0d,%0d) want (6,3)", hpos, vpos);
    end
    tick(1'b1, 1'b1);
    total++;
    if ({hpos, vpos, hsync, vsync, line_start, frame_start} !==
        {10'(HT - 1), 10'(VT - 1), 1'b1, 1'b0, 2'b00}) begin
      bad++;
      $display("FAIL mid_reset_state: got %h want %h", actual, expected());
    end
    tick(1'b0, 1'b1);
    total++;
    if ({hpos, vpos, frame_start, line_start, frame_count} !== {10'd0, 10'd0, 2'b11, 10'd0}) begin
      bad++;
      $display("FAIL mid_reset_release: got %h want %h", actual, expected());
    end
    for (int r = 0; r < 6; r++) begin
      int run = $urandom_range(1, 3 * FT);
      int rlen = $urandom_range(1, 3);
      for (int i = 0; i < run; i++) begin
        tick(1'b0, 1'b1);
        total++;
        if (actual !== expected()) begin
          bad++;
          $display("FAIL rand_run: got %h want %h", actual, expected());
        end
      end
      for (int i = 0; i < rlen; i++) begin
        tick(1'b1, 1'($urandom_range(0, 1)));
        total++;
        if (actual !== expected()) begin
          bad++;
          $display("FAIL rand_reset: got %h want %h", actual, expected());
        end
      end
    end
  endtask

`ifdef VGA_TIMING_CE_EN
  task automatic test_ce();
    int ls_cnt = 0;
    logic [9:0] start_h, start_v;
    start_h = hpos;
    start_v = vpos;
    for (int i = 0; i < 2 * HT; i++) begin
      tick(1'b0, (i % 2) == 0);
      total++;
      if (actual !== expected()) begin
        bad++;
        $display("FAIL ce_alt_model: got %h want %h", actual, expected());
      end
      if (line_start) ls_cnt++;
    end
    total++;
    if (ls_cnt != 1) begin
      bad++;
      $display("FAIL ce_line_start_count: got %0d want 1", ls_cnt);
    end
    total++;
    if (hpos !== start_h || vpos !== 10'((int'(start_v) + 1) % VT)) begin
      bad++;
      $display("FAIL ce_line_length: got (%0d,%0d) want (%0d,%0d)", hpos, vpos,
               start_h, (int'(start_v) + 1) % VT);
    end
  endtask
`endif

  task automatic test_soak();
    for (int i = 0; i < 1500; i++) begin
      tick($urandom_range(0, 63) == 0, 1'($urandom_range(0, 1)));
      total++;
      if (actual !== expected()) begin
        bad++;
        $display("FAIL soak: got %h want %h", actual, expected());
      end
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_frame_wrap();
    test_mid_reset();
`ifdef VGA_TIMING_CE_EN
    test_ce();
`endif
    test_soak();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Generates the raster timing consumed by the pixel colour stage: hsync, vsync, hpos, vpos and visible, plus line/frame strobes and a frame counter. It is the producer end of the pixel-position interface; the colour, sprite and background logic sit downstream of it. Two phase state machines, horizontal and vertical, walk ACTIVE -> FRONT -> SYNC -> BACK. Every output is registered and all outputs are mutually consistent in every cycle.

Parameters:
H_DISPLAY, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync pulse width (clocks)
H_BACK, 48, horizontal back porch (clocks)
V_DISPLAY, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
HSYNC_POL, 0, asserted level of hsync (0 = active-low)
VSYNC_POL, 0, asserted level of vsync (0 = active-low)

Ports:
clk  input  1  pixel clock; the only clock
rst  input  1  synchronous, active-high reset
hsync  output  1  horizontal sync, level set by HSYNC_POL
vsync  output  1  vertical sync, level set by VSYNC_POL
hpos  output  10  pixel column, 0..H_TOTAL-1
vpos  output  10  line number, 0..V_TOTAL-1
visible  output  1  high when hpos<H_DISPLAY and vpos<V_DISPLAY
line_start  output  1  one-cycle strobe when hpos==0
frame_start  output  1  one-cycle strobe when hpos==0 and vpos==0
frame_count  output  10  frame counter, wraps modulo 1024

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800). V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525).
- Reset, sampled at clk edge with rst=1, loads the state of the last clock of a frame:
  - hpos=H_TOTAL-1, vpos=V_TOTAL-1
  - h_state=BACK, v_state=BACK
  - visible=0, line_start=0, frame_start=0
  - hsync=~HSYNC_POL, vsync=~VSYNC_POL
  - frame_count=10'h3FF
- First edge after rst deasserts: hpos=0, vpos=0, visible=1, line_start=1, frame_start=1, frame_count=0.
- Horizontal counter:
  - hpos increments by 1 each clock.
  - At H_TOTAL-1, hpos wraps to 0 and vpos advances.
  - vpos wraps V_TOTAL-1 -> 0 at the same edge that hpos wraps.
- H FSM (tracks hpos, same cycle):
  - ACTIVE: hpos 0..H_DISPLAY-1
  - FRONT: up to H_DISPLAY+H_FRONT-1
  - SYNC: up to +H_SYNC-1
  - BACK: to H_TOTAL-1, then ACTIVE
  - Defaults: SYNC = hpos 656..751.
- V FSM: same four phases on vpos, transitions only on the hpos wrap edge. Defaults: SYNC = vpos 490..491.
- Sync outputs:
  - hsync = HSYNC_POL exactly while h_state==SYNC, otherwise the inverse.
  - vsync = VSYNC_POL while v_state==SYNC for the whole line, hpos 0..799.
- Strobes:
  - line_start is high for exactly the cycle in which hpos==0.
  - frame_start is high only in the cycle with hpos==0 and vpos==0.
- frame_count increments on the edge where the counters move from (H_TOTAL-1, V_TOTAL-1) to (0,0); it wraps 1023 -> 0.
- Latency: all outputs come from flops. No output is combinationally derived from another output, and none skews from the others.
- Reset mid-frame: takes effect on the next edge regardless of state; there is no partial-line recovery.
- Parameter legality: each porch and sync value >=1, H_TOTAL<=1024, V_TOTAL<=1024. Violations are flagged by a simulation-time check.

Optional Feature:
Macro VGA_TIMING_CE_EN.
- Defined: adds input port pix_ce (1 bit).
  - Counters, FSMs and frame_count advance only on edges with pix_ce=1.
  - On pix_ce=0 edges all outputs hold, except line_start and frame_start, which drop to 0. Each strobe is therefore asserted for exactly one clock per position.
  - Reset overrides pix_ce.
- Undefined: no pix_ce port; the block advances every clock.

Test Plan:
1. Reset for 3 clocks, release -> first edge: hpos=0, vpos=0, visible=1, frame_start=1, line_start=1, frame_count=0, hsync=1, vsync=1.
2. Run one line -> hsync low for exactly 96 clocks (hpos 656..751); visible low from hpos 640; line_start pulses every 800 clocks.
3. Run one full frame (420000 clocks) -> vsync low for 1600 clocks (vpos 490..491); frame_start recurs at 420000; frame_count=1.
4. Run 1024 frames with the defaults scaled down (H_DISPLAY=8, H_FRONT=H_SYNC=H_BACK=2, V_DISPLAY=4, V_FRONT=V_SYNC=V_BACK=1) -> frame_count wraps 1023 -> 0; counter-to-FSM consistency holds every cycle.
5. Assert rst at hpos=700, vpos=300 -> next edge shows hpos=799, vpos=524, syncs inactive; the following edge shows (0,0) with frame_start=1.
6. With VGA_TIMING_CE_EN, drive pix_ce alternating 1/0 -> positions advance every 2 clocks; line_start high for 1 clock per line; one line takes 1600 clocks.
